// File: rtl/bias_buf_pkg.sv
// Shared types and helpers for the ping-pong bias buffer.
// Optional shift/saturate path is enabled by BIAS_BUF_SHIFT_EN.
package bias_buf_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_FILL,
    LD_FULL
  } ld_state_e;

  localparam int SHIFT_W = 4;

  function automatic logic signed [63:0] sext64(
    input logic [63:0] v,
    input int unsigned w
  );
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] sat64(
    input logic signed [63:0] v,
    input int unsigned w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/bias_pingpong_buf_bank.sv
// One bias bank: DEPTH entries plus fill count, sequential write,
// LANES-wide read with entries at or beyond the fill count reading as 0.
module bias_bank #(
  parameter int BW    = 8,
  parameter int DEPTH = 64,
  parameter int LANES = 4,
  parameter int GRP_W = 4,
  parameter int CW    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [BW-1:0]         wdata_i,
  input  logic                  clr_i,
  input  logic [GRP_W-1:0]      grp_i,
  output logic [CW-1:0]         cnt_o,
  output logic [LANES*BW-1:0]   rdata_o
);

  localparam int IW = $clog2(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx;

  always_ff @(posedge clk) begin
    if (we_i) mem[cnt_q[IW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (we_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o = cnt_q;

  always_comb begin
    rdata_o = '0;
    idx     = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = CW'(grp_i) * CW'(LANES) + CW'(l);
      if (idx < cnt_q)
        rdata_o[l*BW +: BW] = mem[idx[IW-1:0]];
    end
  end

endmodule

// File: rtl/bias_pingpong_buf.sv
// Ping-pong bias store: loader fills the shadow bank, PE array reads
// the active bank. BIAS_BUF_SHIFT_EN adds a saturating per-read shift.
module bias_pingpong_buf
  import bias_buf_pkg::*;
#(
  parameter int BIAS_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH      = 64,
  parameter int LANES      = 4,
  localparam int GRP_W     = $clog2(DEPTH / LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [BIAS_WIDTH-1:0]      load_data,
  input  logic                       load_last,
  input  logic                       swap,
  output logic                       swap_err,
  output logic                       shadow_full,
  input  logic                       rd_en,
  input  logic [GRP_W-1:0]           rd_grp,
  output logic [LANES*OUT_WIDTH-1:0] bias_out,
  output logic                       bias_valid
`ifdef BIAS_BUF_SHIFT_EN
  ,
  input  logic [SHIFT_W-1:0]         bias_shift
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  if (OUT_WIDTH < BIAS_WIDTH) begin : g_chk_w
    $error("OUT_WIDTH must be >= BIAS_WIDTH");
  end
  if (DEPTH % LANES != 0) begin : g_chk_d
    $error("DEPTH must be a multiple of LANES");
  end

  ld_state_e state_q, state_d;
  logic active_q, rdy_q, swap_err_q, bias_valid_q;
  logic [LANES*OUT_WIDTH-1:0] bias_out_q, lanes_d;

  logic beat, swap_ok, at_end;
  logic [1:0] we, clr;
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] sh_cnt;
  logic [LANES*BIAS_WIDTH-1:0] rd [2];
  logic [LANES*BIAS_WIDTH-1:0] rdata;

  assign load_ready = rdy_q & (state_q != LD_FULL);
  assign beat       = load_valid & load_ready;
  assign swap_ok    = swap & (state_q == LD_FULL);
  assign sh_cnt     = active_q ? cnt[0] : cnt[1];
  assign at_end     = load_last | (sh_cnt == CW'(DEPTH - 1));
  assign we         = {beat & ~active_q, beat & active_q};
  assign clr        = {swap_ok & active_q, swap_ok & ~active_q};
  assign rdata      = active_q ? rd[1] : rd[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bias_bank #(
      .BW    (BIAS_WIDTH),
      .DEPTH (DEPTH),
      .LANES (LANES),
      .GRP_W (GRP_W),
      .CW    (CW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we[b]),
      .wdata_i (load_data),
      .clr_i   (clr[b]),
      .grp_i   (rd_grp),
      .cnt_o   (cnt[b]),
      .rdata_o (rd[b])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE, LD_FILL: if (beat) state_d = at_end ? LD_FULL : LD_FILL;
      LD_FULL:          if (swap) state_d = LD_IDLE;
      default:          state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    lanes_d = '0;
    for (int l = 0; l < LANES; l++) begin
`ifdef BIAS_BUF_SHIFT_EN
      lanes_d[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sat64(
        sext64(64'(rdata[l*BIAS_WIDTH +: BIAS_WIDTH]), BIAS_WIDTH)
          <<< bias_shift, OUT_WIDTH));
`else
      lanes_d[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(
        sext64(64'(rdata[l*BIAS_WIDTH +: BIAS_WIDTH]), BIAS_WIDTH));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LD_IDLE;
      active_q     <= 1'b0;
      rdy_q        <= 1'b0;
      swap_err_q   <= 1'b0;
      bias_valid_q <= 1'b0;
      bias_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_q ^ swap_ok;
      rdy_q        <= 1'b1;
      swap_err_q   <= swap & (state_q != LD_FULL);
      bias_valid_q <= rd_en;
      if (rd_en) bias_out_q <= lanes_d;
    end
  end

  assign swap_err    = swap_err_q;
  assign shadow_full = (state_q == LD_FULL);
  assign bias_out    = bias_out_q;
  assign bias_valid  = bias_valid_q;

endmodule

// File: tb/tb_bias_pingpong_buf.sv
// Directed self-checking bench for bias_pingpong_buf.
// The shift section runs only when BIAS_BUF_SHIFT_EN is defined.
module tb_bias_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, load_last, swap, rd_en;
  logic        load_ready, swap_err, shadow_full, bias_valid;
  logic [7:0]  load_data;
  logic [3:0]  rd_grp;
  logic [63:0] bias_out;
`ifdef BIAS_BUF_SHIFT_EN
  logic [3:0]  bias_shift;
`endif

  int checks = 0;
  int errors = 0;

  bias_pingpong_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .swap        (swap),
    .swap_err    (swap_err),
    .shadow_full (shadow_full),
    .rd_en       (rd_en),
    .rd_grp      (rd_grp),
    .bias_out    (bias_out),
    .bias_valid  (bias_valid)
`ifdef BIAS_BUF_SHIFT_EN
    ,
    .bias_shift  (bias_shift)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp4(input int l0, input int l1,
                                       input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic beat(input int v, input logic last);
    load_valid = 1'b1;
    load_data  = 8'(v);
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic rd(input int g);
    rd_en  = 1'b1;
    rd_grp = 4'(g);
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 0; load_last = 0; load_data = '0;
    swap = 0; rd_en = 0; rd_grp = '0;
`ifdef BIAS_BUF_SHIFT_EN
    bias_shift = '0;
`endif
    #1;
    chk("rst_out", bias_out, 64'd0);
    chk("rst_valid", {63'd0, bias_valid}, 64'd0);
    chk("rst_full", {63'd0, shadow_full}, 64'd0);
    chk("rst_err", {63'd0, swap_err}, 64'd0);
    chk("rst_ready", {63'd0, load_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    chk("ready_rst_cycle", {63'd0, load_ready}, 64'd0);
    tick();
    chk("ready_after", {63'd0, load_ready}, 64'd1);

    // test 1: empty read
    rd(0);
    chk("t1_valid", {63'd0, bias_valid}, 64'd1);
    chk("t1_out", bias_out, 64'd0);
    tick();
    chk("t1_valid_idle", {63'd0, bias_valid}, 64'd0);

    // test 2: full 64-entry set
    for (int i = 0; i < 64; i++) beat(i - 32, 1'b0);
    chk("t2_full", {63'd0, shadow_full}, 64'd1);
    chk("t2_ready_full", {63'd0, load_ready}, 64'd0);
    do_swap();
    chk("t2_full_after", {63'd0, shadow_full}, 64'd0);
    chk("t2_no_err", {63'd0, swap_err}, 64'd0);
    rd(0);
    chk("t2_grp0", bias_out, exp4(-32, -31, -30, -29));
    rd(15);
    chk("t2_grp15", bias_out, exp4(28, 29, 30, 31));

    // test 3: short set, zero padded
    beat(10, 0); beat(-11, 0); beat(12, 0);
    beat(-13, 0); beat(14, 0);
    chk("t3_not_full", {63'd0, shadow_full}, 64'd0);
    beat(-15, 1);
    chk("t3_full", {63'd0, shadow_full}, 64'd1);
    do_swap();
    chk("t3_full_after", {63'd0, shadow_full}, 64'd0);
    rd(1);
    chk("t3_grp1", bias_out, exp4(14, -15, 0, 0));
    rd(0);
    chk("t3_grp0", bias_out, exp4(10, -11, 12, -13));
    rd(2);
    chk("t3_grp2", bias_out, 64'd0);

    // test 4: swap while filling
    beat(1, 0); beat(2, 0); beat(3, 0);
    do_swap();
    chk("t4_err", {63'd0, swap_err}, 64'd1);
    tick();
    chk("t4_err_clr", {63'd0, swap_err}, 64'd0);
    rd(1);
    chk("t4_old_set", bias_out, exp4(14, -15, 0, 0));
    beat(4, 1);
    chk("t4_full", {63'd0, shadow_full}, 64'd1);

    // test 5: read and swap on the same edge
    rd_en = 1'b1; rd_grp = 4'd0; swap = 1'b1;
    tick();
    rd_en = 1'b0; swap = 1'b0;
    chk("t5_pre_swap", bias_out, exp4(10, -11, 12, -13));
    rd(0);
    chk("t5_post_swap", bias_out, exp4(1, 2, 3, 4));

    // load_last on the first beat
    beat(-7, 1);
    chk("t6_full", {63'd0, shadow_full}, 64'd1);
    do_swap();
    rd(0);
    chk("t6_grp0", bias_out, exp4(-7, 0, 0, 0));
    rd(1);
    chk("t6_grp1", bias_out, 64'd0);

    // reset during load and after read
    beat(5, 0); beat(6, 0);
    rst_n = 1'b0;
    #1;
    chk("t7_out", bias_out, 64'd0);
    chk("t7_ready", {63'd0, load_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(0);
    chk("t7_read", bias_out, 64'd0);
    chk("t7_ready_after", {63'd0, load_ready}, 64'd1);

`ifdef BIAS_BUF_SHIFT_EN
    beat(127, 0); beat(-128, 0); beat(3, 1);
    do_swap();
    bias_shift = 4'd9;
    rd(0);
    chk("t8_sat", bias_out, {16'h0000, 16'h0600, 16'h8000, 16'h7FFF});
    bias_shift = 4'd2;
    rd(0);
    chk("t8_shift2", bias_out, exp4(508, -512, 12, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
